// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit and its lane aligner.
// - Access size encodings (byte/half/word/illegal).
// - FSM state encoding.
// - Big-endian lane position constants and helpers.
package mau_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_RD = 2'd1,
    ST_ACC_WR = 2'd2,
    ST_RESP   = 2'd3
  } mau_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  // Big-endian: byte lane 0 is the most significant byte of the word.
  localparam logic [4:0] BYTE0_LSB   = 5'd24;
  localparam logic [4:0] HALF_HI_LSB = 5'd16;
  localparam logic [4:0] HALF_LO_LSB = 5'd0;

  function automatic logic [4:0] byte_lsb(input logic [1:0] lane);
    return BYTE0_LSB - {lane, 3'b000};
  endfunction

  function automatic logic [4:0] half_lsb(input logic lo_sel);
    return lo_sel ? HALF_LO_LSB : HALF_HI_LSB;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane aligner for a big-endian word-only memory.
// Ports:
//   word      in  32  word read from memory
//   lane      in   2  byte offset within the word (addr[1:0])
//   size      in   2  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   sign_ext  in   1  sign-extend sub-word loads
//   wdata     in  16  right-justified store data (low byte/half used)
//   load_data out 32  extracted and extended load value
//   merged    out 32  word with the store data merged into its lane
module mem_lane_align
  import mau_pkg::*;
(
  input  logic [31:0]       word,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [HALF_W-1:0] wdata,
  output logic [31:0]       load_data,
  output logic [31:0]       merged
);

  logic [4:0]        b_lsb;
  logic [4:0]        h_lsb;
  logic [BYTE_W-1:0] b;
  logic [HALF_W-1:0] h;

  always_comb begin
    b_lsb     = byte_lsb(lane);
    h_lsb     = half_lsb(lane[1]);
    b         = BYTE_W'(word >> b_lsb);
    h         = HALF_W'(word >> h_lsb);
    load_data = word;
    merged    = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{(32 - BYTE_W){sign_ext & b[BYTE_W-1]}}, b};
        merged    = (word & ~(32'h0000_00FF << b_lsb)) |
                    (32'(wdata[BYTE_W-1:0]) << b_lsb);
      end
      SZ_HALF: begin
        load_data = {{(32 - HALF_W){sign_ext & h[HALF_W-1]}}, h};
        merged    = (word & ~(32'h0000_FFFF << h_lsb)) |
                    (32'(wdata) << h_lsb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller in front of a word-only data_memory.
// Accepts byte/half/word loads and stores, word-aligns the address,
// extends sub-word loads and performs read-modify-write for sub-word
// stores. A memory access completes when mem_vivi toggles.
// Ports:
//   clock, reset0                 clock, synchronous active-low reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_we/size/signed/addr/wdata request fields
//   resp_valid/resp_rdata/resp_err one-cycle completion pulse and result
//   mem_visit/addr/data/we        to data_memory
//   mem_outp/valid/vivi           from data_memory
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 262144,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic        clock,
  input  logic        reset0,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_visit,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  input  logic [31:0] mem_outp,
  input  logic        mem_valid,
  input  logic        mem_vivi
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mau_state_e        state;
  logic              a_we;
  logic [1:0]        a_size;
  logic              a_signed;
  logic [1:0]        a_lane;
  logic [HALF_W-1:0] a_wdata;
  logic              err_q;
  logic [31:0]       load_q;
  logic              vivi_ref;
  logic [CNT_W-1:0]  cnt;

  logic              req_bad;
  logic              vivi_hit;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign req_ready = (state == ST_IDLE);
  assign vivi_hit  = (mem_vivi != vivi_ref);

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      SZ_HALF: req_bad = req_addr[0];
      SZ_WORD: req_bad = |req_addr[1:0];
      SZ_BAD:  req_bad = 1'b1;
      default: ;
    endcase
    if (({1'b0, req_addr} + 33'd3) >= 33'(MEM_SIZE))
      req_bad = 1'b1;
  end

  mem_lane_align u_align (
    .word      (mem_outp),
    .lane      (a_lane),
    .size      (a_size),
    .sign_ext  (a_signed),
    .wdata     (a_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clock) begin
    if (!reset0) begin
      state      <= ST_IDLE;
      a_we       <= 1'b0;
      a_size     <= SZ_BYTE;
      a_signed   <= 1'b0;
      a_lane     <= '0;
      a_wdata    <= '0;
      err_q      <= 1'b0;
      load_q     <= '0;
      vivi_ref   <= mem_vivi;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_visit  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Track vivi while idle so the reference is current on entry.
          vivi_ref <= mem_vivi;
          cnt      <= '0;
          if (req_valid) begin
            a_we     <= req_we;
            a_size   <= req_size;
            a_signed <= req_signed;
            a_lane   <= req_addr[1:0];
            a_wdata  <= req_wdata[HALF_W-1:0];
            load_q   <= '0;
            if (req_bad) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              err_q     <= 1'b0;
              mem_visit <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              if (req_we && req_size == SZ_WORD) begin
                mem_we   <= 1'b1;
                mem_data <= req_wdata;
                state    <= ST_ACC_WR;
              end else begin
                mem_we   <= 1'b0;
                mem_data <= '0;
                state    <= ST_ACC_RD;
              end
            end
          end
        end

        ST_ACC_RD, ST_ACC_WR: begin
          if (vivi_hit) begin
            cnt <= '0;
            if (!mem_valid) begin
              err_q     <= 1'b1;
              mem_visit <= 1'b0;
              mem_we    <= 1'b0;
              state     <= ST_RESP;
            end else if (state == ST_ACC_RD && a_we) begin
              // RMW: visit stays high and turns into the write access.
              mem_data <= merged;
              mem_we   <= 1'b1;
              vivi_ref <= mem_vivi;
              state    <= ST_ACC_WR;
            end else begin
              if (!a_we)
                load_q <= load_data;
              mem_visit <= 1'b0;
              mem_we    <= 1'b0;
              state     <= ST_RESP;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            mem_visit <= 1'b0;
            mem_we    <= 1'b0;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= err_q ? '0 : load_q;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: negedge word memory model,
// byte-array reference model, directed plus randomized requests.
module tb_mem_access_unit;

  localparam int unsigned MEM_SIZE  = 262144;
  localparam int unsigned MEM_WORDS = MEM_SIZE / 4;
  localparam int unsigned TIMEOUT   = 8;

  logic        clock = 1'b0;
  logic        reset0;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_visit;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic [31:0] mem_outp;
  logic        mem_valid;
  logic        mem_vivi;

  int errors = 0;
  int checks = 0;

  bit          stall_mode   = 1'b0;
  bit          invalid_mode = 1'b0;
  int          visit_cycles = 0;
  int          served       = 0;
  logic [7:0]  we_hist      = '0;
  logic [31:0] last_rdata;

  logic [31:0] mem     [MEM_WORDS];
  logic [7:0]  ref_mem [MEM_SIZE];

  assign mem_valid = ~invalid_mode;

  always #5 clock = ~clock;

  mem_access_unit #(.MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset0     (reset0),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_visit  (mem_visit),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_outp   (mem_outp),
    .mem_valid  (mem_valid),
    .mem_vivi   (mem_vivi)
  );

  // data_memory model: services one access per negedge with visit high.
  always @(negedge clock) begin
    if (mem_visit) begin
      visit_cycles++;
      if (!stall_mode) begin
        if (mem_we) mem[mem_addr[17:2]] = mem_data;
        else        mem_outp = mem[mem_addr[17:2]];
        mem_vivi = ~mem_vivi;
        served++;
        we_hist = {we_hist[6:0], mem_we};
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a big-endian byte array.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int unsigned n,
                                           input bit sgn);
    longint v = 0;
    for (int unsigned i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[addr + i]);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input int unsigned n, input logic [31:0] wd);
    for (int unsigned i = 0; i < n; i++) ref_mem[addr + i] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[17:2]] = w;
    ref_store({addr[31:2], 2'b00}, 4, w);
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned n, guard, lat, e_lat, e_vis, e_srv;
    int          vis0, srv0;
    bit          bad, e_err, rmw;
    logic [31:0] e_rd;
    n     = 1 << size;
    bad   = (size == 2'd3) || (addr % n != 0) || (({32'd0, addr} + 64'd3) >= 64'(MEM_SIZE));
    e_rd  = '0;
    e_err = 1'b0;
    rmw   = 1'b0;
    if (bad) begin
      e_err = 1; e_lat = 1; e_vis = 0; e_srv = 0;
    end else if (stall_mode) begin
      e_err = 1; e_lat = TIMEOUT + 1; e_vis = TIMEOUT; e_srv = 0;
    end else if (invalid_mode) begin
      e_err = 1; e_lat = 2; e_vis = 1; e_srv = 1;
    end else if (!we) begin
      e_lat = 2; e_vis = 1; e_srv = 1; e_rd = ref_load(addr, n, sgn);
    end else if (n == 4) begin
      e_lat = 2; e_vis = 1; e_srv = 1; ref_store(addr, n, wdata);
    end else begin
      e_lat = 3; e_vis = 2; e_srv = 2; rmw = 1; ref_store(addr, n, wdata);
    end

    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clock); #1; guard++;
    end
    check("ready", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    vis0 = visit_cycles;
    srv0 = served;
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (!bad) check("mem_addr", mem_addr, {addr[31:2], 2'b00});
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
    last_rdata = resp_rdata;
    check("latency", lat, e_lat);
    check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
    check("resp_rdata", resp_rdata, e_rd);
    check("visit_cycles", 32'(visit_cycles - vis0), e_vis);
    check("served", 32'(served - srv0), e_srv);
    check("visit_low", {31'd0, mem_visit}, 32'd0);
    if (rmw) check("rmw_we_seq", {30'd0, we_hist[1:0]}, 32'd1);
    if (we && !e_err)
      check("mem_word", mem[addr[17:2]], ref_load({addr[31:2], 2'b00}, 4, 1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int unsigned r;
    reset0     = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = '0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_outp   = '0;
    mem_vivi   = 1'b0;
    for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] = '0;
    for (int unsigned i = 0; i < MEM_SIZE; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_visit", {31'd0, mem_visit}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    reset0 = 1'b1;
    @(posedge clock); #1;

    preload(32'h100, 32'h8123_45F6);
    preload(32'h104, 32'h1357_9BDF);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("ld_word_const", last_rdata, 32'h8123_45F6);
    do_req(1'b0, 2'd0, 1'b1, 32'h100, 32'h0);
    check("ld_byte_s_const", last_rdata, 32'hFFFF_FF81);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    check("ld_byte_u_const", last_rdata, 32'h0000_00F6);
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    check("ld_half_s_const", last_rdata, 32'h0000_45F6);
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AA);
    check("st_byte_const", mem[32'h100 >> 2], 32'h81AA_45F6);

    do_req(1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, MEM_SIZE - 2, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);

    stall_mode = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    stall_mode = 1'b0;

    invalid_mode = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    do_req(1'b1, 2'd0, 1'b0, 32'h102, 32'h0000_0011);
    invalid_mode = 1'b0;
    check("invalid_no_write", mem[32'h100 >> 2], 32'h81AA_45F6);

    // Reset during the write half of a byte-store RMW.
    while (!req_ready) begin @(posedge clock); #1; end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h105; req_wdata = 32'h0000_005A;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("rmw_rd_we", {31'd0, mem_we}, 32'd0);
    @(posedge clock); #1;
    check("rmw_wr_we", {31'd0, mem_we}, 32'd1);
    reset0 = 1'b0;
    @(posedge clock); #1;
    check("midrst_visit", {31'd0, mem_visit}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_resp", {31'd0, resp_valid}, 32'd0);
    reset0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    // The write may or may not have landed; resync the reference word.
    ref_store(32'h104, 4, mem[32'h104 >> 2]);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    check("post_rst_load", last_rdata, 32'h81AA_45F6);

    for (int unsigned i = 0; i < 32; i++)
      preload(32'h100 + 4 * i, $urandom);
    preload(MEM_SIZE - 4, $urandom);
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      ra = MEM_SIZE - $urandom_range(1, 8);
      else if (r == 1) ra = $urandom;
      else             ra = 32'h100 + $urandom_range(0, 127);
      do_req(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
             1'($urandom), ra, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage controller sitting directly upstream of data_memory. Drives its port: visit, addr, data, write_enable.
- Accepts byte, half and word load/store requests from the pipeline MEM stage.
- data_memory is word-only, so the unit word-aligns addresses and does sign/zero extension on loads.
- Sub-word stores use read-modify-write; completion is detected from the memory's vivi toggle.

Parameters:
- MEM_SIZE, 262144, byte capacity of the attached memory; addr+3 >= MEM_SIZE is an error.
- TIMEOUT, 8, cycles to wait for a vivi toggle before flagging an error.

Ports:
- clock  in  1  system clock; unit logic on posedge.
- reset0  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  misaligned, out of range, illegal size, timeout or mem_valid=0.
- mem_visit  out  1  to data_memory.visit.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_data  out  32  to data_memory.data.
- mem_we  out  1  to data_memory.write_enable.
- mem_outp  in  32  from data_memory.outp.
- mem_valid  in  1  from data_memory.valid.
- mem_vivi  in  1  from data_memory.vivi; toggles once per serviced access.

Behaviour:
- Reset (reset0 = 0 at posedge):
  - state goes to IDLE.
  - req_ready = 1; resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - mem_visit = 0, mem_we = 0, mem_addr = 0, mem_data = 0; timeout counter = 0.
  - vivi_ref is loaded from mem_vivi.
- Byte order is big-endian within a word:
  - Byte lane k = addr[1:0] occupies bits [31-8k -: 8].
  - Half lane addr[1] = 0 is [31:16]; addr[1] = 1 is [15:0].
- States: IDLE, ACC_RD, ACC_WR, RESP.
- IDLE:
  - Accepts on req_valid && req_ready; all request fields are registered.
  - Error check: size 3; half with addr[0] = 1; word with addr[1:0] != 0; out of range.
  - On error: go to RESP with err = 1, and no memory access is made.
  - Load: go to ACC_RD.
  - Word store: go to ACC_WR.
  - Byte or half store: go to ACC_RD, then ACC_WR (read-modify-write).
- Entering any ACC state:
  - mem_visit = 1 (registered); mem_we = 1 only in ACC_WR.
  - vivi_ref is captured from mem_vivi; the counter is cleared.
- ACC completion:
  - Completes on the first posedge where mem_vivi != vivi_ref.
  - mem_visit and mem_we drop on that same edge, so exactly one memory access happens per ACC state.
- ACC_RD completion: capture mem_outp.
  - For a load: extract the lane, extend per req_signed, then go to RESP.
  - For a sub-word store: merge req_wdata's low byte/half into the captured word at the lane; that merged word becomes mem_data for ACC_WR.
- ACC_WR: mem_data is the full word (word store) or the merged word.
- mem_valid = 0 at completion: go to RESP with err = 1.
- Timeout: counter reaches TIMEOUT without a toggle → drop mem_visit, go to RESP with err = 1.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no back-pressure on the response.
- Latency from the accept edge to resp_valid high:
  - error: 1 cycle.
  - load or word store: 2 cycles.
  - sub-word store: 3 cycles.
  - Throughput: one request per (latency + 1) cycles.
- Reset mid-operation: mem_visit drops on the reset edge and no response is issued. At most one memory access already sampled may complete; a half-done RMW may leave the read done but the write not done.
- resp_rdata holds its value between pulses; it is 0 for stores and errors.

Decomposition:
- Shared package mau_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - state enum.
  - lane bit-position constants.
- One sub-module, mem_lane_align (combinational): extract plus extend for loads, merge for stores. It is reused by the later cache controller.

Test Plan:
- Preload word@0x100 = 32'h8123_45F6. Load word 0x100 → resp_rdata 32'h812345F6, err 0; resp_valid 2 cycles after accept; exactly one mem_visit cycle.
- Load byte 0x100 signed → 32'hFFFF_FF81. Load byte 0x103 unsigned → 32'h0000_00F6. Load half 0x102 signed → 32'h0000_45F6.
- Store byte 0x101 data 32'h0000_00AA over 32'h8123_45F6:
  - two visits: write_enable 0, then 1.
  - memory word becomes 32'h81AA_45F6; resp 3 cycles after accept.
- Misaligned or out-of-range cases, each → err 1, resp 1 cycle after accept, mem_visit never asserted:
  - half at 0x101.
  - word at 0x102.
  - word at MEM_SIZE-2.
- Memory model that never toggles vivi → err 1 after TIMEOUT cycles, with mem_visit low afterwards.
- reset0 low during ACC_WR of an RMW → on the next edge mem_visit = 0, req_ready = 1, resp_valid stays 0; a following word load completes normally.
